// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : SPI mode-3 responder (CPOL=1, CPHA=1, MSB first, 8-bit frames,
//             active-low slave select). SCLK/SS/MOSI are oversampled in the
//             local clk domain. Each received byte is delivered with a
//             one-cycle pulse. The byte to send is supplied through a
//             one-entry valid/ready transmit buffer.
//  Ports    : clk, rst            local clock, synchronous active-high reset
//             i_sclk, i_ss, i_mosi  asynchronous SPI pins from the master
//             o_miso, o_miso_oe   slave data out and pad output enable
//             i_tx_data/i_tx_valid/o_tx_ready  transmit byte handshake
//             o_rx_data/o_rx_valid received byte and its update pulse
//             o_busy              frame in progress
//             o_tx_underrun       frame started with an empty TX buffer
//             o_frame_err         SS released before 8 bits were received
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_tx_underrun,
  output logic       o_frame_err
);

  // --------------------------------------------------------------------------
  // Synchronizers plus one history stage per asynchronous input. All stages
  // reset high so that idle pins produce no edge after reset.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_h;
  logic                   r_ss_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_ss_sync   <= '1;
      r_mosi_sync <= '1;
      r_sclk_h    <= 1'b1;
      r_ss_h      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_h    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_h      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  logic w_s_sclk;
  logic w_s_ss;
  logic w_s_mosi;
  logic w_sclk_fall;
  logic w_sclk_rise;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_active;

  assign w_s_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_s_ss      = r_ss_sync[SYNC_STAGES-1];
  assign w_s_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_fall = ~w_s_sclk &  r_sclk_h;
  assign w_sclk_rise =  w_s_sclk & ~r_sclk_h;
  assign w_ss_fall   = ~w_s_ss   &  r_ss_h;
  assign w_ss_rise   =  w_s_ss   & ~r_ss_h;
  // SS is judged from the history stage: the final SCLK rise and the SS
  // release reach the synchronized stage together, and that rise must still
  // count as part of the frame.
  assign w_active    = ~r_ss_h;

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;
  logic   w_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
          w_end       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift datapath
  // --------------------------------------------------------------------------
  logic [7:0] r_tx_shreg;
  logic [7:0] r_rx_shreg;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_rx_data;
  logic       r_done;
  logic       r_rx_valid;
  logic       r_tx_underrun;
  logic       r_frame_err;
  logic [7:0] r_buf;
  logic       r_buf_full;

  logic       w_in_shift;
  logic       w_rise_q;
  logic       w_fall_q;
  logic       w_bit_done;
  logic [3:0] w_cnt_next;
  logic       w_tx_wr;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_rise_q   = w_in_shift & w_sclk_rise & w_active;
  // The fall that coincides with ss_fall is seen while still in IDLE, so it
  // never shifts; the first data bit stays on o_miso for the first rise.
  assign w_fall_q   = w_in_shift & w_sclk_fall;
  assign w_bit_done = w_rise_q & (r_bit_cnt == 4'd7);
  // Count saturates at 8 so extra rises inside one frame are ignored.
  assign w_cnt_next = (w_rise_q && (r_bit_cnt != 4'd8)) ? r_bit_cnt + 4'd1
                                                        : r_bit_cnt;
  assign w_tx_wr    = i_tx_valid & ~r_buf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shreg    <= 8'hFF;
      r_rx_shreg    <= 8'h00;
      r_bit_cnt     <= 4'd0;
      r_rx_data     <= 8'h00;
      r_done        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_rx_valid    <= r_done;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_start) begin
        r_tx_shreg    <= r_buf_full ? r_buf : IDLE_BYTE;
        r_tx_underrun <= ~r_buf_full;
        r_bit_cnt     <= 4'd0;
        r_rx_shreg    <= 8'h00;
      end else if (w_in_shift) begin
        if (w_rise_q && (r_bit_cnt != 4'd8)) begin
          r_rx_shreg <= {r_rx_shreg[6:0], w_s_mosi};
          r_bit_cnt  <= w_cnt_next;
        end
        if (w_bit_done) begin
          r_rx_data <= {r_rx_shreg[6:0], w_s_mosi};
          r_done    <= 1'b1;
        end
        if (w_fall_q) begin
          r_tx_shreg <= {r_tx_shreg[6:0], 1'b0};
        end
        if (w_end && (w_cnt_next != 4'd8)) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // One-entry transmit buffer. The frame-start consume is applied first so a
  // write in that same cycle (only possible when already empty) survives for
  // the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
    end else begin
      if (w_start) begin
        r_buf_full <= 1'b0;
      end
      if (w_tx_wr) begin
        r_buf      <= i_tx_data;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign o_miso        = r_tx_shreg[7];
  assign o_miso_oe     = w_active;
  assign o_busy        = w_active;
  assign o_tx_ready    = ~r_buf_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_tx_underrun;
  assign o_frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Self-checking bench for spi_slave. A behavioural SPI mode-3
//             master drives frames; a byte-level model predicts captured
//             MISO bytes, received bytes and status pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave;

  localparam int C_SYNC = 2;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;
  logic       frame_err;

  spi_slave #(
    .SYNC_STAGES (C_SYNC),
    .IDLE_BYTE   (8'hFF)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_sclk        (sclk),
    .i_ss          (ss),
    .i_mosi        (mosi),
    .o_miso        (miso),
    .o_miso_oe     (miso_oe),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_busy        (busy),
    .o_tx_underrun (tx_underrun),
    .o_frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative pulse counters; frames work with deltas.
  int n_rxv = 0;
  int n_ur  = 0;
  int n_fe  = 0;
  int rxv_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_rxv   = n_rxv + 1;
        rxv_cyc = cyc;
      end
      if (tx_underrun) n_ur = n_ur + 1;
      if (frame_err)   n_fe = n_fe + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: byte-level view of the slave.
  logic [7:0] mdl_buf;
  bit         mdl_full;
  logic [7:0] mdl_rx;
  int         rise_cyc;

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    check_eq("tx_ready_before_wr", tx_ready, !mdl_full);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    mdl_full = 1'b1;
    mdl_buf  = b;
    check_eq("tx_ready_after_wr", tx_ready, 0);
  endtask

  // Mode-3 master: SS and the first SCLK fall together, data changes on
  // falls, sampled on rises; the last rise releases SS.
  task automatic run_frame(input logic [7:0] mo, input int nr, input int hp,
                           input bit mid_wr, input logic [7:0] mid_b,
                           output logic [7:0] mi);
    mi = 8'h00;
    @(negedge clk);
    ss = 1'b0; sclk = 1'b0; mosi = mo[7];
    for (int b = 0; b < nr; b++) begin
      repeat (hp) @(negedge clk);
      if (b == 1) begin
        check_eq("busy_mid", busy, 1);
        check_eq("oe_mid", miso_oe, 1);
        check_eq("tx_ready_consumed", tx_ready, 1);
      end
      if (b == 2 && mid_wr) begin
        tx_valid = 1'b1;
        tx_data  = mid_b;
      end
      if (b == 3 && mid_wr) check_eq("tx_ready_low_mid", tx_ready, 0);
      mi   = {mi[6:0], miso};
      sclk = 1'b1;
      if (b == nr - 1) begin
        ss       = 1'b1;
        rise_cyc = cyc;
      end else begin
        repeat (hp) @(negedge clk);
        tx_valid = 1'b0;
        sclk = 1'b0;
        mosi = mo[6-b];
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] mo, input int nr, input int hp,
                          input bit mid_wr, input logic [7:0] mid_b);
    logic [7:0] exp_mi;
    logic [7:0] got;
    bit         exp_ur;
    int         v0, u0, f0;
    exp_mi   = mdl_full ? mdl_buf : 8'hFF;
    exp_ur   = !mdl_full;
    mdl_full = 1'b0;
    v0 = n_rxv; u0 = n_ur; f0 = n_fe;
    run_frame(mo, nr, hp, mid_wr, mid_b, got);
    if (mid_wr) begin
      mdl_full = 1'b1;
      mdl_buf  = mid_b;
    end
    repeat (12) @(negedge clk);
    check_eq("miso_bits", got, exp_mi >> (8 - nr));
    check_eq("underrun_cnt", n_ur - u0, exp_ur);
    if (nr == 8) begin
      mdl_rx = mo;
      check_eq("rx_valid_cnt", n_rxv - v0, 1);
      check_eq("frame_err_cnt", n_fe - f0, 0);
      check_eq("rx_valid_lat", rxv_cyc - rise_cyc, C_SYNC + 2);
    end else begin
      check_eq("rx_valid_cnt_abort", n_rxv - v0, 0);
      check_eq("frame_err_cnt_abort", n_fe - f0, 1);
    end
    check_eq("rx_data", rx_data, mdl_rx);
    check_eq("busy_idle", busy, 0);
    check_eq("oe_idle", miso_oe, 0);
    check_eq("tx_ready_idle", tx_ready, !mdl_full);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, u0, f0;
    int nr, hp;
    bit mw;
    logic [7:0] mo, mb;

    rst = 1'b1; sclk = 1'b1; ss = 1'b1; mosi = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    mdl_full = 1'b0; mdl_buf = 8'h00; mdl_rx = 8'h00; rise_cyc = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_miso", miso, 1);
    check_eq("rst_oe", miso_oe, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underrun", tx_underrun, 0);
    check_eq("rst_frame_err", frame_err, 0);

    // SCLK activity without SS must be ignored.
    v0 = n_rxv; u0 = n_ur; f0 = n_fe;
    for (int i = 0; i < 20; i++) begin
      repeat (3) @(negedge clk);
      sclk = ~sclk;
      mosi = i[0];
    end
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("noss_oe", miso_oe, 0);
    check_eq("noss_pulses", (n_rxv - v0) + (n_ur - u0) + (n_fe - f0), 0);

    // Buffered byte, then an underrun frame.
    tx_write(8'hA5);
    do_frame(8'h3C, 8, 4, 1'b0, 8'h00);
    do_frame(8'hC3, 8, 4, 1'b0, 8'h00);

    // Back-to-back with a write during the first frame.
    do_frame(8'h11, 8, 4, 1'b1, 8'h01);
    do_frame(8'h22, 8, 4, 1'b0, 8'h00);

    // Short frame, then a good one.
    do_frame(8'h77, 5, 4, 1'b0, 8'h00);
    do_frame(8'h81, 8, 4, 1'b0, 8'h00);

    // Reset in the middle of a frame.
    @(negedge clk);
    ss = 1'b0; sclk = 1'b0; mosi = 1'b1;
    for (int b = 0; b < 3; b++) begin
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      mosi = b[0];
    end
    rst = 1'b1; ss = 1'b1; sclk = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    mdl_full = 1'b0; mdl_rx = 8'h00;
    v0 = n_rxv; f0 = n_fe;
    repeat (12) @(negedge clk);
    check_eq("rstmid_rx_valid", n_rxv - v0, 0);
    check_eq("rstmid_frame_err", n_fe - f0, 0);
    check_eq("rstmid_rx_data", rx_data, 0);
    check_eq("rstmid_tx_ready", tx_ready, 1);
    do_frame(8'h5A, 8, 4, 1'b0, 8'h00);

    // Randomized frames against the model.
    for (int k = 0; k < 30; k++) begin
      mo = 8'($urandom);
      mb = 8'($urandom);
      hp = int'($urandom_range(4, 6));
      nr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      mw = ($urandom_range(0, 2) == 0) && (nr >= 4);
      if (!mdl_full && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
      do_frame(mo, nr, hp, mw, mb);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI responder (mode 3: CPOL=1, CPHA=1, MSB first, 8-bit frames, active-low SS) for the far end of the `spi` master link. It oversamples SCLK/SS/MOSI in the local `clk` domain, delivers each received byte as a one-cycle pulse, and shifts out a byte supplied through a valid/ready transmit handshake. It sits between the pad-level SPI pins and a byte-oriented local consumer.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `ss`, `mosi`; legal values are 2 or more.
- `IDLE_BYTE`, 8'hFF: byte shifted out when no transmit data is buffered at frame start.
- `clk`  in  1  local clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master; asynchronous; idles high.
- `ss`  in  1  slave select, active low; asynchronous.
- `mosi`  in  1  master-out data; asynchronous.
- `miso`  out  1  slave-out data; bit 7 of the TX shift register.
- `miso_oe`  out  1  high while SS is synchronized-asserted; drives the pad tri-state.
- `tx_data`  in  8  byte to send in a following frame.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding buffer is empty. A transfer occurs when `tx_valid && tx_ready`.
- `rx_data`  out  8  last received byte; held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  a frame is in progress (synchronized SS low).
- `tx_underrun`  out  1  one-cycle pulse when a frame starts with an empty buffer.
- `frame_err`  out  1  one-cycle pulse when SS deasserts before 8 bits are received.

## Operation
- **Sync chain.** Each async input passes through `SYNC_STAGES` flops, then one history flop. Definitions:
  - fall = `s_sclk & ~h_sclk == 0 & 1` (sync low, history high); rise is the reverse.
  - `ss_fall` and `ss_rise` are defined the same way on `ss`.
  - `active` = `h_ss == 0`, i.e. SS is low in the history stage.
- **States.** IDLE and SHIFT.
- **IDLE → SHIFT on `ss_fall`:**
  - Load `tx_shreg` with the buffer byte if the buffer is full, otherwise with `IDLE_BYTE` and pulse `tx_underrun`.
  - Empty the buffer. Clear `bit_cnt` (4 bits) and `rx_shreg`.
  - The SCLK fall that coincides with `ss_fall` does not shift `tx_shreg`.
- **In SHIFT:**
  - On rise: `rx_shreg <= {rx_shreg[6:0], s_mosi}` and `bit_cnt++`.
  - On fall (not coincident with `ss_fall`): `tx_shreg <= {tx_shreg[6:0], 1'b0}`.
- **Frame complete.** On the rise where `bit_cnt == 7`, `rx_data` takes `{rx_shreg[6:0], s_mosi}` and `rx_valid` pulses next cycle.
  - The master's final SCLK rise coincides with SS release. Both arrive in the same sync stage, so rise is qualified by `active` (the history stage), not by `s_ss`.
- **SHIFT → IDLE on `ss_rise`:**
  - If `bit_cnt != 8` (counting the completing rise in the same cycle), pulse `frame_err` and do not pulse `rx_valid`.
  - Any loaded TX byte is discarded.
- **Extra edges.** Rises after 8 bits while SS stays low are ignored; `bit_cnt` saturates at 8. Falls after bit 0 shift in zeros.
- **TX buffer.** One entry. `tx_ready = ~buf_full`. A write during the same cycle as `ss_fall` is not seen by that frame; it lands in the now-empty buffer for the next frame.
- **Reset values.**
  - Outputs: `miso`=1 (`tx_shreg` = 8'hFF), `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `tx_underrun`=0, `frame_err`=0.
  - Internal state: IDLE, sync flops all set to 1.
  - Reset mid-frame abandons the frame with no pulses. The slave re-arms only on the next `ss_fall`.

## Timing
- An input edge becomes visible as fall/rise `SYNC_STAGES` cycles later. `miso` updates one cycle after that (3 cycles with `SYNC_STAGES`=2).
- Requirement: every SCLK half-period and every SS setup to the first SCLK rise is at least `SYNC_STAGES`+2 local clocks. A master divisor of 8 on an equal-frequency clock meets this with `SYNC_STAGES`=2.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the final SCLK rise.
- `busy` follows `~h_ss`.
- `tx_ready` rises the cycle after `ss_fall` if the buffer was full.

## Test plan
- Reset, then check every output against the reset values; hold `ss`=1 and toggle `sclk` → no pulses, `miso_oe`=0.
- Write `tx_data`=8'hA5; run a master frame with MOSI 8'h3C at half-period 4 → `rx_data`=8'h3C, exactly one `rx_valid` pulse; master captures 8'hA5; `tx_underrun`=0.
- Run a frame with no TX write → master reads 8'hFF, `tx_underrun` pulses once at frame start, `rx_valid` still pulses.
- Two back-to-back frames, writing 8'h01 during the first frame → second frame returns 8'h01; `tx_ready` is low between the write and the second `ss_fall`.
- Deassert SS after 5 SCLK rises → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged; the next full frame with 8'h81 is received correctly.
- Assert `rst` after 3 bits, release, then run a full frame of 8'h5A → no `frame_err`, no stale data, `rx_data`=8'h5A.
